// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared glyph table and digit-field constants for the seven-segment scanner
package seven_seg_pkg;
  localparam int DIG_W = 5;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [4:0] BLANK_CODE = 5'b10000;
  localparam logic [7:0] GLYPH [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };
endpackage

// File: rtl/seven_seg_glyph.sv
// seven_seg_glyph: 5-bit digit code plus decimal point to active-low segment pattern
module seven_seg_glyph
  import seven_seg_pkg::*;
(
  input  logic [DIG_W-1:0] code,
  input  logic             dp,
  output logic [7:0]       seg
);
  assign seg = code[4] ? SEG_OFF : {GLYPH[code[3:0]][7:1], ~dp};
endmodule

// File: rtl/seven_seg_scan_n.sv
// seven_seg_scan_n: N-digit multiplexed 7-seg scanner with double buffer; SEVENSEG_DIM_EN adds brightness PWM
module seven_seg_scan_n
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIG  = 4,
  parameter int PRESCALE = 65536,
  parameter int DEAD     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DIG_W*NUM_DIG-1:0] data_in,
  input  logic [NUM_DIG-1:0]       dp_in,
  input  logic                     load,
  input  logic [3:0]               bright,
  output logic                     busy,
  output logic                     frame_start,
  output logic [7:0]               seg,
  output logic [NUM_DIG-1:0]       anode
);
  localparam int SW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int IW = NUM_DIG > 1 ? $clog2(NUM_DIG) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(PRESCALE - 1);
  localparam logic [SW-1:0] DEAD_S = SW'(DEAD);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIG - 1);
  logic [SW-1:0] slot_cnt;
  logic [IW-1:0] idx;
  logic [DIG_W*NUM_DIG-1:0] act_data, pend_data;
  logic [NUM_DIG-1:0] act_dp, pend_dp, anode_nxt;
  logic [DIG_W-1:0] code;
  logic [7:0] glyph;
  logic slot_wrap, commit, gate;
  assign slot_wrap = slot_cnt == SLOT_LAST;
  assign commit = slot_wrap && idx == IDX_LAST && busy;
  assign code = act_data[DIG_W*idx +: DIG_W];
  assign anode_nxt = (slot_cnt >= DEAD_S && gate) ? ~(NUM_DIG'(1) << idx) : '1;
  seven_seg_glyph u_glyph (
    .code (code),
    .dp   (act_dp[idx]),
    .seg  (glyph)
  );
`ifdef SEVENSEG_DIM_EN
  logic [3:0] phase;
  always_ff @(posedge clk)
    phase <= !rst_n ? 4'd0 : phase + 4'd1;
  assign gate = phase <= bright;
`else
  logic unused_bright;
  assign unused_bright = ^bright;
  assign gate = 1'b1;
`endif
  // commit takes the old pending value; a coincident load refills pending and keeps busy high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt    <= '0;
      idx         <= '0;
      act_data    <= {NUM_DIG{BLANK_CODE}};
      pend_data   <= {NUM_DIG{BLANK_CODE}};
      act_dp      <= '0;
      pend_dp     <= '0;
      busy        <= 1'b0;
      frame_start <= 1'b0;
      seg         <= SEG_OFF;
      anode       <= '1;
    end else begin
      slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
      if (slot_wrap)
        idx <= idx == IDX_LAST ? '0 : idx + 1'b1;
      if (commit) begin
        act_data <= pend_data;
        act_dp   <= pend_dp;
      end
      if (load) begin
        pend_data <= data_in;
        pend_dp   <= dp_in;
      end
      busy        <= load | (busy & ~commit);
      frame_start <= slot_cnt == '0 && idx == '0;
      seg         <= glyph;
      anode       <= anode_nxt;
    end
  end
endmodule
